frc_cache_drain: RTL and testbench

Sequential reader for one force cache (home or neighbour) that sweeps particle IDs `0..num_particles-1` after force evaluation. It reads each accumulated force, clears the entry to zero through the cache write port, and streams `(parid, force)` to the motion-update stage over a valid/ready handshake. It sits on the opposite side of the cache from the force accumulators, and one instance is placed per cache.

---
 rtl/MD_pkg.sv | 27 ++
 rtl/frc_drain_fifo.sv | 54 +++++
 rtl/frc_cache_drain.sv | 150 +++++++++++++++
 tb/tb_frc_cache_drain.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/MD_pkg.sv
`default_nettype none
// ============================================================================
// Module      : MD_pkg
// Description : Shared MD types and constants used by the force-cache blocks.
// Revision    : 1.0  initial release
// ============================================================================
package MD_pkg;

    localparam int PARTICLE_ID_WIDTH    = 4;
    localparam int FRC_DRAIN_FIFO_DEPTH = 4;

    typedef logic [31:0] float_data_t;

    typedef struct packed {
        logic [PARTICLE_ID_WIDTH-1:0] parid;
        float_data_t                  frc;
    } frc_beat_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/frc_drain_fifo.sv
`default_nettype none
// ============================================================================
// Module      : frc_drain_fifo
// Description : Synchronous show-ahead FIFO with occupancy count output.
// Revision    : 1.0  initial release
// ============================================================================
module frc_drain_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head_data,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int               c_aw         = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_full_count = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push    = push && (r_count != c_full_count);
    assign w_pop     = pop && (r_count != '0);
    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage is left unreset; the consumer only looks at the head while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{c_aw{1'b0}}, w_push} - {{c_aw{1'b0}}, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/frc_cache_drain.sv
`default_nettype none
// ============================================================================
// Module      : frc_cache_drain
// Description : Sweeps a force cache, clears each entry and streams (parid, force).
// Revision    : 1.0  initial release
// ============================================================================
module frc_cache_drain
    import MD_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = FRC_DRAIN_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PARTICLE_ID_WIDTH:0]   num_particles,
    output logic [PARTICLE_ID_WIDTH-1:0] frc_rd_addr,
    input  float_data_t                  frc_rd_data,
    output logic                         frc_wr_en,
    output logic [PARTICLE_ID_WIDTH-1:0] frc_wr_addr,
    output float_data_t                  frc_wr_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PARTICLE_ID_WIDTH-1:0] out_parid,
    output float_data_t                  out_frc,
    output logic                         busy,
    output logic                         done
);
    localparam int c_id_w  = PARTICLE_ID_WIDTH;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    drain_state_t        r_state;
    logic [c_id_w:0]     r_next_id;
    logic [c_id_w:0]     r_num;
    logic [c_id_w-1:0]   r_rd_addr;
    logic [RD_LATENCY:0] r_pipe_vld;
    logic [c_id_w-1:0]   r_pipe_id [RD_LATENCY+1];
    logic                r_busy;
    logic                r_done;

    logic [c_cnt_w-1:0]  w_fifo_count;
    logic [c_cnt_w-1:0]  w_inflight;
    logic                w_credit_ok;
    logic                w_start_issue;
    logic                w_issue;
    logic [c_id_w:0]     w_issue_id;
    logic [c_id_w:0]     w_next_after;
    logic                w_pop;
    logic                w_flush_empty;
    frc_beat_t           w_push_beat;
    frc_beat_t           w_head_beat;

    // Stage 0 of the pipe is aligned with the address register, so the tail
    // (stage RD_LATENCY) lines up with the cache returning data.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= RD_LATENCY; i++) begin
            w_inflight = w_inflight + {{(c_cnt_w-1){1'b0}}, r_pipe_vld[i]};
        end
    end

    assign w_credit_ok   = ({1'b0, w_inflight} + {1'b0, w_fifo_count}) < (c_cnt_w+1)'(FIFO_DEPTH);
    assign w_start_issue = (r_state == S_IDLE) && start && (num_particles != '0);
    assign w_issue       = w_start_issue ||
                           ((r_state == S_ISSUE) && (r_next_id < r_num) && w_credit_ok);
    assign w_issue_id    = w_start_issue ? '0 : r_next_id;
    assign w_next_after  = w_issue ? (w_issue_id + 1'b1) : r_next_id;
    assign w_pop         = out_valid && out_ready;
    // True when nothing will remain in flight or buffered after this edge.
    assign w_flush_empty = (r_pipe_vld == '0) &&
                           ((w_fifo_count == '0) || ((w_fifo_count == c_cnt_w'(1)) && w_pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_next_id  <= '0;
            r_num      <= '0;
            r_rd_addr  <= '0;
            r_pipe_vld <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) r_pipe_id[i] <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_pipe_vld <= {r_pipe_vld[RD_LATENCY-1:0], w_issue};
            r_pipe_id[0] <= w_issue_id[c_id_w-1:0];
            for (int i = 1; i <= RD_LATENCY; i++) r_pipe_id[i] <= r_pipe_id[i-1];
            if (w_issue) begin
                r_rd_addr <= w_issue_id[c_id_w-1:0];
                r_next_id <= w_next_after;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num  <= num_particles;
                        r_busy <= 1'b1;
                        if (num_particles == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_next_after == r_num) r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (w_flush_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_push_beat.parid = r_pipe_id[RD_LATENCY];
    assign w_push_beat.frc   = frc_rd_data;

    frc_drain_fifo #(
        .WIDTH ($bits(frc_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_pipe_vld[RD_LATENCY]),
        .push_data (w_push_beat),
        .pop       (w_pop),
        .head_data (w_head_beat),
        .count     (w_fifo_count)
    );

    assign frc_rd_addr = r_rd_addr;
    assign frc_wr_en   = r_pipe_vld[RD_LATENCY];
    assign frc_wr_addr = r_pipe_id[RD_LATENCY];
    assign frc_wr_data = '0;
    assign out_valid   = (w_fifo_count != '0);
    assign out_parid   = out_valid ? w_head_beat.parid : '0;
    assign out_frc     = out_valid ? w_head_beat.frc : '0;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_frc_cache_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_frc_cache_drain
// Description : Self-checking bench for frc_cache_drain with a behavioural cache.
// Revision    : 1.0  initial release
// ============================================================================
module tb_frc_cache_drain;
    import MD_pkg::*;

    localparam int RDL   = 1;
    localparam int DEPTH = FRC_DRAIN_FIFO_DEPTH;
    localparam int IDW   = PARTICLE_ID_WIDTH;
    localparam int NID   = 1 << IDW;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IDW:0]      num_particles;
    logic [IDW-1:0]    frc_rd_addr;
    float_data_t       frc_rd_data;
    logic              frc_wr_en;
    logic [IDW-1:0]    frc_wr_addr;
    float_data_t       frc_wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDW-1:0]    out_parid;
    float_data_t       out_frc;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    frc_cache_drain #(.RD_LATENCY(RDL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .num_particles(num_particles),
        .frc_rd_addr(frc_rd_addr), .frc_rd_data(frc_rd_data),
        .frc_wr_en(frc_wr_en), .frc_wr_addr(frc_wr_addr), .frc_wr_data(frc_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_parid(out_parid),
        .out_frc(out_frc), .busy(busy), .done(done)
    );

    // Behavioural force cache: registered read with RDL cycles of latency.
    float_data_t    mem [NID];
    float_data_t    rd_pipe [RDL];
    logic           tb_wr_en;
    logic [IDW-1:0] tb_wr_addr;
    float_data_t    tb_wr_data;

    always @(posedge clk) begin
        rd_pipe[0] <= mem[frc_rd_addr];
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
        else if (frc_wr_en) mem[frc_wr_addr] <= frc_wr_data;
    end
    assign frc_rd_data = rd_pipe[RDL-1];

    int          checks, errors;
    int          e, t;
    int          mode;
    int          n_cur, nb, nc;
    int          done_cnt, done_cyc;
    int          max_addr, first_valid_e;
    bit          pass_active, hold_v;
    logic [IDW-1:0] hold_parid, last_parid;
    float_data_t hold_frc;
    float_data_t preload [NID];
    float_data_t basic_val [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (out_valid === 1'b1 && first_valid_e < 0) first_valid_e = e;
        if (hold_v) begin
            check("hold_valid", 64'(out_valid), 1);
            check("hold_parid", 64'(out_parid), 64'(hold_parid));
            check("hold_frc", 64'(out_frc), 64'(hold_frc));
        end
        hold_v     = (out_valid === 1'b1) && (out_ready === 1'b0);
        hold_parid = out_parid;
        hold_frc   = out_frc;
        if (pass_active && n_cur > 0) begin
            if (int'(frc_rd_addr) > max_addr) max_addr = int'(frc_rd_addr);
            check("outstanding", 64'((max_addr + 1 - nb) <= DEPTH), 1);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check("beat_in_range", 64'(nb < n_cur), 1);
            check("beat_parid", 64'(out_parid), 64'(nb[IDW-1:0]));
            check("beat_frc", 64'(out_frc), 64'(preload[nb % NID]));
            last_parid = out_parid;
            nb++;
        end
        if (frc_wr_en === 1'b1) begin
            check("clr_in_range", 64'(nc < n_cur), 1);
            check("clr_addr", 64'(frc_wr_addr), 64'(nc[IDW-1:0]));
            check("clr_data", 64'(frc_wr_data), 0);
            nc++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = e + 1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        e++;
        #1;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = (first_valid_e >= 0) && (e >= first_valid_e + 10);
        endcase
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_out_valid"}, 64'(out_valid), 0);
        check({tag, "_wr_en"}, 64'(frc_wr_en), 0);
        check({tag, "_rd_addr"}, 64'(frc_rd_addr), 0);
        check({tag, "_wr_addr"}, 64'(frc_wr_addr), 0);
        check({tag, "_out_parid"}, 64'(out_parid), 0);
        check({tag, "_out_frc"}, 64'(out_frc), 0);
    endtask

    task automatic load_cache();
        for (int i = 0; i < NID; i++) begin
            tb_wr_en   = 1'b1;
            tb_wr_addr = i[IDW-1:0];
            tb_wr_data = preload[i];
            cycle();
        end
        tb_wr_en = 1'b0;
    endtask

    task automatic randomize_cache();
        for (int i = 0; i < NID; i++) preload[i] = $urandom;
        load_cache();
    endtask

    task automatic start_pass(input int n, input int md);
        n_cur = n; mode = md; nb = 0; nc = 0; done_cnt = 0; done_cyc = -1;
        max_addr = -1; first_valid_e = -1;
        num_particles = n[IDW:0];
        start = 1'b1;
        cycle();
        t = e;
        start = 1'b0;
        pass_active = 1'b1;
    endtask

    task automatic run_pass(input int n, input int md, input int busy_at, input int post);
        start_pass(n, md);
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            start = (busy_at > 0) && (e == t + busy_at);
            cycle();
        end
        start = 1'b0;
        pass_active = 1'b0;
        repeat (post) cycle();
        check("done_count", 64'(done_cnt), 1);
        if (md == 0) check("done_time", 64'(done_cyc), 64'((n == 0) ? t + 1 : t + 3 + RDL + n - 1));
        check("beats_total", 64'(nb), 64'(n));
        check("clears_total", 64'(nc), 64'(n));
        check("idle_busy", 64'(busy), 0);
        check("idle_valid", 64'(out_valid), 0);
        for (int i = 0; i < NID; i++) begin
            check("cache_after", 64'(mem[i]), 64'((i < n) ? 32'h0 : preload[i]));
            if (i < n) preload[i] = '0;
        end
    endtask

    initial begin
        checks = 0; errors = 0; e = 0; t = 0; mode = 0;
        n_cur = 0; nb = 0; nc = 0; done_cnt = 0; done_cyc = -1;
        max_addr = -1; first_valid_e = -1; pass_active = 1'b0; hold_v = 1'b0;
        hold_parid = '0; hold_frc = '0; last_parid = '0;
        rst = 1'b1; start = 1'b0; num_particles = '0; out_ready = 1'b1;
        tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
        basic_val[0] = 32'h3f800000; basic_val[1] = 32'h40000000;
        basic_val[2] = 32'h40400000; basic_val[3] = 32'h40800000;
        cycle(); cycle();
        rst = 1'b0;
        check_outputs_zero("reset");

        // Basic drain with known forces
        for (int i = 0; i < NID; i++) preload[i] = (i < 4) ? basic_val[i] : $urandom;
        load_cache();
        run_pass(4, 0, 0, 3);

        // Back-pressure: ready low for 10 cycles after first valid
        randomize_cache();
        run_pass(8, 2, 0, 3);

        // Zero-length pass
        run_pass(0, 0, 0, 3);

        // Start pulse during FLUSH is ignored
        randomize_cache();
        run_pass(3, 2, 4, 5);

        // Mid-pass reset after two beats
        randomize_cache();
        start_pass(6, 0);
        for (int k = 0; k < 50 && nb < 2; k++) cycle();
        check("mr_two_beats", 64'(nb), 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        pass_active = 1'b0;
        hold_v = 1'b0;
        check_outputs_zero("mr");
        done_cnt = 0;
        repeat (20) cycle();
        check("mr_no_done", 64'(done_cnt), 0);
        check("mr_id0_cleared", 64'(mem[0]), 0);
        check("mr_id4_kept", 64'(mem[4]), 64'(preload[4]));
        check("mr_id5_kept", 64'(mem[5]), 64'(preload[5]));

        // Full ID range with random ready
        randomize_cache();
        run_pass(NID, 1, 0, 0);
        check("full_last_parid", 64'(last_parid), 64'(NID - 1));

        // Immediate restart in the cycle after done
        randomize_cache();
        run_pass(5, 0, 0, 0);
        run_pass(9, 0, 0, 2);

        // Randomised passes
        repeat (3) begin
            randomize_cache();
            run_pass($urandom_range(1, NID), 1, 0, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
